drum_sample_player: RTL and testbench
=====================================

Name: drum_sample_player

Overview:
- Playback sequencer for a single-port on-chip sample ROM/RAM (16-bit words, registered address, unregistered q, 1-cycle read latency).
- On a trigger it steps through one stored sample (e.g. cymbal) at audio rate and fetches one word per audio tick.
- It emits a continuous 16-bit PCM stream to the mixer, with silence when idle.
- It is the sole read master of the memory's s1 port; writes go through the debug path only.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, sample word width (signed PCM).
- SAMPLE_BASE, 0, first word address of the sample.
- SAMPLE_LEN, 48384, number of words to play (≥1; SAMPLE_BASE+SAMPLE_LEN ≤ 2^ADDR_W).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle audio-rate strobe; minimum spacing 4 clk.
- trigger  in  1  one-cycle pulse; start or restart playback.
- stop  in  1  one-cycle pulse; abort playback.
- mem_address  out  ADDR_W  word address to memory.
- mem_chipselect  out  1  memory select.
- mem_clken  out  1  memory clock enable.
- mem_byteenable  out  DATA_W/8  all ones whenever chipselect is high, otherwise 0.
- mem_readdata  in  DATA_W  memory q (valid the cycle after the address is registered).
- sample_out  out  DATA_W  current PCM sample.
- sample_valid  out  1  one-cycle strobe per tick.
- busy  out  1  playback active.
- done  out  1  one-cycle pulse coincident with the last word's sample_valid.
- overrun  out  1  one-cycle pulse when a tick is dropped.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0.
  - ptr=SAMPLE_BASE, state=IDLE, pending-trigger and pending-stop flags cleared.
  - Reset mid-fetch aborts immediately; no sample_valid or done is produced.
- States: IDLE, PLAY, ISSUE, FETCH.
  - IDLE: no playback. A tick goes to ISSUE with rd_silent=1 and does not drive the memory. trigger → PLAY, ptr=SAMPLE_BASE, busy=1 from the next cycle.
  - PLAY: a tick at cycle T → ISSUE at T+1.
  - ISSUE (T+1): mem_address=ptr, mem_chipselect=mem_clken=1 for exactly this cycle → FETCH.
  - FETCH (T+2): capture mem_readdata. At T+3: sample_out=captured word, sample_valid=1, ptr=ptr+1. Then go to PLAY, or to IDLE on the last word.
- Silent tick (IDLE): sample_valid=1 at T+3 with sample_out=0. The stream rate is therefore constant.
- Latency: tick → sample_valid is exactly 3 clk, in all states.
- Last word (ptr==SAMPLE_BASE+SAMPLE_LEN-1):
  - done=1 together with its sample_valid.
  - busy=0 and state=IDLE from T+4.
  - sample_out holds the last word until the next silent tick drives it to 0.
- trigger in PLAY: ptr=SAMPLE_BASE immediately; no done pulse.
- trigger in ISSUE/FETCH: latched as pending. The current fetch completes and outputs normally, then ptr=SAMPLE_BASE and state=PLAY. done is suppressed even if the current word was the last.
- stop: in PLAY → IDLE next cycle. In ISSUE/FETCH → latched; the current word is output, then IDLE. done is not pulsed.
- trigger and stop in the same cycle: trigger wins; stop is discarded.
- Tick in ISSUE/FETCH: the tick is ignored and overrun=1 for one cycle. State and ptr are unaffected.
- Memory outputs are 0 in all states except ISSUE.
- ptr arithmetic is ADDR_W-bit unsigned; the last-word compare prevents wrap past the sample.

Optional Feature:
- Macro: SAMPLE_PLAYER_LOOP_EN.
- Defined: adds input port loop_en (1 bit).
  - At the last word with loop_en=1: ptr wraps to SAMPLE_BASE, state stays PLAY, busy stays 1, and done is not pulsed.
  - loop_en is sampled in the FETCH cycle of the last word.
  - stop still terminates playback.
- Undefined: no loop_en port; playback is always one-shot as above.

Test Plan:
1. reset_n low during FETCH → all outputs 0 immediately. After release, a tick gives sample_valid at +3 with sample_out=0, and busy stays 0.
2. SAMPLE_BASE=0x0010, SAMPLE_LEN=4, memory words 0x1111/0x2222/0x3333/0x4444; trigger, then ticks every 8 clk:
   - sample_valid at tick+3 with those values in order.
   - mem_address 0x0010..0x0013, each with chipselect/clken high for one cycle only.
   - done with 0x4444; the next tick outputs 0.
3. Same setup, trigger asserted in the ISSUE cycle of the 2nd word → 0x2222 is still output, then the next tick fetches 0x0010 (0x1111). No done pulse.
4. trigger and stop in the same cycle while in PLAY at word 2 → playback restarts at 0x0010 and busy stays 1.
5. Two ticks 2 clk apart → one sample_valid only, overrun=1 on the second tick, and ptr advances by exactly 1.
6. With SAMPLE_PLAYER_LOOP_EN and loop_en=1, LEN=4 → 8 ticks yield 1111,2222,3333,4444,1111,2222,3333,4444 with no done pulse. Then stop → busy=0 and subsequent samples are 0.

Source files
------------

// File: rtl/drum_sample_player.sv
// Drum sample playback sequencer: one ROM word per audio tick, silence when idle.
// Optional looping playback enabled by defining SAMPLE_PLAYER_LOOP_EN.
module drum_sample_player #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int SAMPLE_BASE = 0,
  parameter int SAMPLE_LEN  = 48384
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_tick,
  input  logic                trigger,
  input  logic                stop,
`ifdef SAMPLE_PLAYER_LOOP_EN
  input  logic                loop_en,
`endif
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_clken,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [DATA_W-1:0]   sample_out,
  output logic                sample_valid,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(SAMPLE_BASE);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(SAMPLE_BASE + SAMPLE_LEN - 1);

  typedef enum logic [1:0] {IDLE, PLAY, ISSUE, FETCH} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              silent;
  logic              hold;
  logic              wrap;
  logic              pend_trig;
  logic              pend_stop;

  logic              loop;
  logic              trig_now;
  logic              stop_now;
  logic              play_stop;
  logic              go;
  logic              is_last;
  logic [ADDR_W-1:0] start;

`ifdef SAMPLE_PLAYER_LOOP_EN
  assign loop = loop_en;
`else
  assign loop = 1'b0;
`endif

  // Later request wins while a fetch is in flight; trigger beats stop.
  assign trig_now  = trigger | (pend_trig & ~stop);
  assign stop_now  = ~trigger & (stop | pend_stop);
  assign play_stop = stop & ~trigger;
  assign go        = (state == PLAY || trigger) && !play_stop;
  assign start     = trigger ? BASE : ptr;
  assign is_last   = ptr == LAST;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      ptr            <= BASE;
      silent         <= 1'b0;
      hold           <= 1'b0;
      wrap           <= 1'b0;
      pend_trig      <= 1'b0;
      pend_stop      <= 1'b0;
      mem_address    <= '0;
      mem_chipselect <= 1'b0;
      mem_clken      <= 1'b0;
      mem_byteenable <= '0;
      sample_out     <= '0;
      sample_valid   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
      unique case (state)
        IDLE, PLAY: begin
          if (trigger) begin
            ptr  <= BASE;
            busy <= 1'b1;
          end
          if (sample_tick) begin
            state  <= ISSUE;
            hold   <= 1'b0;
            silent <= !go;
            if (go) begin
              mem_address    <= start;
              mem_chipselect <= 1'b1;
              mem_clken      <= 1'b1;
              mem_byteenable <= '1;
            end
            if (play_stop) busy <= 1'b0;
          end else if (play_stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (trigger) begin
            state <= PLAY;
          end
        end
        ISSUE: begin
          state          <= FETCH;
          mem_address    <= '0;
          mem_chipselect <= 1'b0;
          mem_clken      <= 1'b0;
          mem_byteenable <= '0;
          overrun        <= sample_tick;
          pend_trig      <= trig_now;
          pend_stop      <= stop_now;
        end
        FETCH: begin
          overrun   <= sample_tick;
          pend_trig <= trig_now;
          pend_stop <= stop_now;
          if (!hold) begin
            // First FETCH cycle: q is valid now, present it next cycle.
            hold         <= 1'b1;
            sample_valid <= 1'b1;
            sample_out   <= silent ? '0 : mem_readdata;
            done         <= !silent && is_last && !loop
                            && !trig_now && !stop_now;
            wrap         <= loop;
          end else begin
            hold      <= 1'b0;
            pend_trig <= 1'b0;
            pend_stop <= 1'b0;
            if (trig_now) begin
              state <= PLAY;
              ptr   <= BASE;
              busy  <= 1'b1;
            end else if (silent || stop_now || (is_last && !wrap)) begin
              state <= IDLE;
              ptr   <= BASE;
              busy  <= 1'b0;
            end else begin
              state <= PLAY;
              ptr   <= is_last ? BASE : ptr + ADDR_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drum_sample_player.sv
// Self-checking bench for drum_sample_player: 4-word sample at 0x0010.
// Randomized trigger/stop/tick traffic against a sample-index playback model.
module tb_drum_sample_player;

  localparam int BASE = 16;
  localparam int LEN  = 4;
  localparam logic [15:0] WORDS [4] =
    '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_tick;
  logic        trigger;
  logic        stop;
  logic [15:0] mem_address;
  logic        mem_chipselect;
  logic        mem_clken;
  logic [1:0]  mem_byteenable;
  logic [15:0] mem_readdata;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [15:0] addr_q = '0;
`ifdef SAMPLE_PLAYER_LOOP_EN
  logic        loop_en;
`endif

  int passed = 0;
  int total  = 0;

  bit m_play;
  int m_idx;
  bit m_loop;

  always #5 clk = ~clk;

  drum_sample_player #(
    .ADDR_W(16),
    .DATA_W(16),
    .SAMPLE_BASE(BASE),
    .SAMPLE_LEN(LEN)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sample_tick(sample_tick),
    .trigger(trigger),
    .stop(stop),
`ifdef SAMPLE_PLAYER_LOOP_EN
    .loop_en(loop_en),
`endif
    .mem_address(mem_address),
    .mem_chipselect(mem_chipselect),
    .mem_clken(mem_clken),
    .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata),
    .sample_out(sample_out),
    .sample_valid(sample_valid),
    .busy(busy),
    .done(done),
    .overrun(overrun)
  );

  function automatic logic [15:0] rom(input logic [15:0] a);
    int i = int'(a) - BASE;
    if (i >= 0 && i < LEN) return WORDS[i];
    return a ^ 16'hA5A5;
  endfunction

  // Single-port memory: registered address, unregistered q.
  always @(posedge clk)
    if (mem_chipselect && mem_clken) addr_q <= mem_address;
  assign mem_readdata = rom(addr_q);

  function automatic logic [63:0] pack(
    input logic v, input logic dn, input logic b4,
    input logic [15:0] d, input int mc, input int mo,
    input logic [15:0] a, input int st);
    return 64'({v, dn, b4, d, 4'(mc), 4'(mo), a, 8'(st)});
  endfunction

  task automatic model_trigger();
    m_play = 1'b1;
    m_idx  = 0;
  endtask

  task automatic model_stop();
    m_play = 1'b0;
  endtask

  // inj: 0 none, 1 trigger during ISSUE, 2 stop during FETCH
  task automatic model_tick(input int inj, output logic [63:0] e);
    logic [15:0] d = '0;
    logic [15:0] a = '0;
    logic dn = 1'b0;
    int cs = 0;
    if (m_play) begin
      cs = 1;
      a  = 16'(BASE + m_idx);
      d  = WORDS[m_idx];
      if (m_idx == LEN - 1) begin
        if (m_loop) m_idx = 0;
        else begin
          dn = 1'b1;
          m_play = 1'b0;
        end
      end else m_idx++;
    end
    if (inj == 1) begin
      dn = 1'b0;
      model_trigger();
    end
    if (inj == 2) begin
      dn = 1'b0;
      model_stop();
    end
    e = pack(1'b1, dn, m_play, d, cs, cs, a, 0);
  endtask

  task automatic pulse(input logic t, input logic s);
    trigger = t;
    stop    = s;
    @(posedge clk); #1;
    trigger = 1'b0;
    stop    = 1'b0;
  endtask

  // One tick plus 8 observed cycles; obs packs what the DUT did.
  task automatic run_tick(input int inj, output logic [63:0] obs);
    logic v = 1'b0;
    logic dn = 1'b0;
    logic b4 = 1'b0;
    logic [15:0] d = '0;
    logic [15:0] a = '0;
    int mc = 0;
    int mo = 0;
    int st = 0;
    sample_tick = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      sample_tick = 1'b0;
      trigger     = (c == 1 && inj == 1);
      stop        = (c == 2 && inj == 2);
      if (mem_chipselect || mem_clken || mem_byteenable != 0) begin
        mc++;
        a = mem_address;
      end
      if (mem_chipselect && mem_clken && mem_byteenable == 2'b11) mo++;
      if (c == 3) begin
        v  = sample_valid;
        d  = sample_out;
        dn = done;
      end else if (sample_valid || done) st++;
      if (overrun) st++;
      if (c == 4) b4 = busy;
    end
    trigger = 1'b0;
    stop    = 1'b0;
    obs = pack(v, dn, b4, d, mc, mo, a, st);
  endtask

  task automatic test_reset();
    logic [63:0] o;
    repeat (3) @(posedge clk);
    #1;
    o = 64'({sample_valid, done, overrun, busy, mem_chipselect,
             mem_clken, mem_byteenable, mem_address, sample_out});
    total++;
    if (o !== 64'd0) $display("FAIL reset_state got %h want 0", o);
    else passed++;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_one_shot();
    logic [63:0] e, o;
    pulse(1'b1, 1'b0);
    model_trigger();
    total++;
    if (busy !== 1'b1) $display("FAIL trig_busy got %b want 1", busy);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      model_tick(0, e);
      run_tick(0, o);
      total++;
      if (o !== e) $display("FAIL one_shot%0d got %h want %h", i, o, e);
      else passed++;
    end
  endtask

  task automatic test_retrigger();
    logic [63:0] e, o;
    int seq [8] = '{0, 1, 0, 0, 0, 1, 0, 2};
    pulse(1'b1, 1'b0);
    model_trigger();
    for (int i = 0; i < 8; i++) begin
      model_tick(seq[i], e);
      run_tick(seq[i], o);
      total++;
      if (o !== e) $display("FAIL retrig%0d got %h want %h", i, o, e);
      else passed++;
    end
  endtask

  task automatic test_trig_stop();
    logic [63:0] e, o;
    pulse(1'b1, 1'b0);
    model_trigger();
    model_tick(0, e);
    run_tick(0, o);
    pulse(1'b1, 1'b1);
    model_trigger();
    total++;
    if (busy !== 1'b1) $display("FAIL trig_stop_busy got %b want 1", busy);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      model_tick(0, e);
      run_tick(0, o);
      total++;
      if (o !== e) $display("FAIL trig_stop%0d got %h want %h", i, o, e);
      else passed++;
    end
    pulse(1'b0, 1'b1);
    model_stop();
    total++;
    if (busy !== 1'b0) $display("FAIL stop_busy got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_overrun();
    logic [63:0] e, o;
    int vcnt = 0;
    int ocnt = 0;
    int o_at = -1;
    logic [15:0] d = '0;
    pulse(1'b1, 1'b0);
    model_trigger();
    model_tick(0, e);
    sample_tick = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      sample_tick = (c == 2);
      if (sample_valid) vcnt++;
      if (overrun) begin
        ocnt++;
        o_at = c;
      end
      if (c == 3) d = sample_out;
    end
    o = 64'({8'(vcnt), 8'(ocnt), 8'(o_at), d});
    e = 64'({8'd1, 8'd1, 8'd3, WORDS[0]});
    total++;
    if (o !== e) $display("FAIL overrun got %h want %h", o, e);
    else passed++;
    model_tick(0, e);
    run_tick(0, o);
    total++;
    if (o !== e) $display("FAIL after_overrun got %h want %h", o, e);
    else passed++;
    pulse(1'b0, 1'b1);
    model_stop();
  endtask

  task automatic test_reset_mid_fetch();
    logic [63:0] e, o;
    int vcnt = 0;
    pulse(1'b1, 1'b0);
    model_trigger();
    model_tick(0, e);
    run_tick(0, o);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    o = 64'({sample_valid, done, overrun, busy, mem_chipselect,
             mem_clken, mem_byteenable, mem_address, sample_out});
    total++;
    if (o !== 64'd0) $display("FAIL reset_fetch got %h want 0", o);
    else passed++;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) reset_n = 1'b1;
      if (sample_valid || done) vcnt++;
    end
    model_stop();
    total++;
    if (vcnt !== 0) $display("FAIL reset_abort got %0d want 0", vcnt);
    else passed++;
    model_tick(0, e);
    run_tick(0, o);
    total++;
    if (o !== e) $display("FAIL post_reset got %h want %h", o, e);
    else passed++;
  endtask

  task automatic test_random();
    logic [63:0] e, o;
    int r;
    pulse(1'b0, 1'b1);
    model_stop();
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        pulse(r != 2, r >= 2);
        if (r == 2) model_stop();
        else model_trigger();
        total++;
        if (busy !== m_play)
          $display("FAIL rnd_busy%0d got %b want %b", i, busy, m_play);
        else passed++;
      end else begin
        model_tick(r == 4 ? 1 : (r == 5 ? 2 : 0), e);
        run_tick(r == 4 ? 1 : (r == 5 ? 2 : 0), o);
        total++;
        if (o !== e) $display("FAIL rnd_tick%0d got %h want %h", i, o, e);
        else passed++;
      end
    end
    pulse(1'b0, 1'b1);
    model_stop();
  endtask

`ifdef SAMPLE_PLAYER_LOOP_EN
  task automatic test_loop();
    logic [63:0] e, o;
    loop_en = 1'b1;
    m_loop  = 1'b1;
    pulse(1'b1, 1'b0);
    model_trigger();
    for (int i = 0; i < 8; i++) begin
      model_tick(0, e);
      run_tick(0, o);
      total++;
      if (o !== e) $display("FAIL loop%0d got %h want %h", i, o, e);
      else passed++;
    end
    pulse(1'b0, 1'b1);
    model_stop();
    total++;
    if (busy !== 1'b0) $display("FAIL loop_stop got %b want 0", busy);
    else passed++;
    model_tick(0, e);
    run_tick(0, o);
    total++;
    if (o !== e) $display("FAIL loop_silent got %h want %h", o, e);
    else passed++;
    loop_en = 1'b0;
    m_loop  = 1'b0;
  endtask
`endif

  initial begin
    reset_n     = 1'b0;
    sample_tick = 1'b0;
    trigger     = 1'b0;
    stop        = 1'b0;
`ifdef SAMPLE_PLAYER_LOOP_EN
    loop_en     = 1'b0;
`endif
    m_play = 1'b0;
    m_idx  = 0;
    m_loop = 1'b0;
    test_reset();
    test_one_shot();
    test_retrigger();
    test_trig_stop();
    test_overrun();
    test_reset_mid_fetch();
    test_random();
`ifdef SAMPLE_PLAYER_LOOP_EN
    test_loop();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
